// File: rtl/updown_key_pkg.sv
// Shared types, default parameter values and width helper for the up/down key front end.
package updown_key_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      REPEAT  = 2'd2,
      PRESSED = 2'd3
   } key_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_DELAY    = 500;
   localparam int DEF_REPEAT_PERIOD   = 100;

   function automatic int cnt_width(input int max_val);
      return (max_val < 32'sd1) ? 32'sd1 : $clog2(max_val + 32'sd1);
   endfunction

endpackage

// File: rtl/updown_key_ctrl_debounce.sv
// key_debounce: 2-FF synchroniser plus counter debounce for one raw button, with
// single-cycle strobes on the cycle the debounced level flips.
module key_debounce
   import updown_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic          rise_r;
   logic          fall_r;
   logic [CW-1:0] cnt_r;
   logic          mismatch_s;

   assign mismatch_s = sync2_r ^ level_r;

   // synchroniser, debounce counter and flip strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
         cnt_r   <= '0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
         if (!mismatch_s) begin
            cnt_r <= '0;
         end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            level_r <= sync2_r;
            rise_r  <= sync2_r;
            fall_r  <= ~sync2_r;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   assign level = level_r;
   assign rise  = rise_r;
   assign fall  = fall_r;

endmodule

// File: rtl/updown_key_ctrl.sv
// updown_key_ctrl: debounced up/down buttons to exclusive single-cycle count pulses.
// Hold-to-repeat is compiled in only when UPDOWN_KEY_AUTO_REPEAT_EN is defined.
module updown_key_ctrl
   import updown_key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_up,
   input  logic btn_down,
   output logic up,
   output logic down,
   output logic busy
);

   if (DEBOUNCE_CYCLES < 32'sd2 || REPEAT_DELAY < 32'sd2 || REPEAT_PERIOD < 32'sd2) begin : g_bad_cfg
      $error("updown_key_ctrl: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
   end

`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
   localparam int TW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
`endif

   // index 0 = increment key, index 1 = decrement key
   logic [1:0] lvl_s;
   logic [1:0] rise_s;
   logic [1:0] fall_s;
   logic [1:0] pulse_s;
   logic       both_s;
   logic       up_r;
   logic       down_r;
   logic       busy_r;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_up),
      .level (lvl_s[0]),
      .rise  (rise_s[0]),
      .fall  (fall_s[0])
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_down),
      .level (lvl_s[1]),
      .rise  (rise_s[1]),
      .fall  (fall_s[1])
   );

   assign both_s = lvl_s[0] & lvl_s[1];

   for (genvar g = 0; g < 2; g++) begin : g_key
      key_state_t state_r;
      key_state_t state_nxt_s;
      logic       press_s;
      logic       pulse_k_s;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
      logic [TW-1:0] tmr_r;
      logic [TW-1:0] tmr_nxt_s;
`endif

      // a release of the other key while this one is held counts as a fresh press
      assign press_s = lvl_s[g] & (rise_s[g] | fall_s[1-g]);

      // next state, repeat timer and pulse request for this key
      always_comb begin
         state_nxt_s = state_r;
         pulse_k_s   = 1'b0;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
         tmr_nxt_s   = tmr_r;
`endif
         if (both_s) begin
            state_nxt_s = IDLE;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
            tmr_nxt_s   = '0;
`endif
         end else begin
            case (state_r)
               IDLE: begin
                  if (press_s) begin
                     pulse_k_s = 1'b1;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
                     state_nxt_s = HOLD;
                     tmr_nxt_s   = DELAY_LOAD;
`else
                     state_nxt_s = PRESSED;
`endif
                  end else begin
                     state_nxt_s = IDLE;
                  end
               end
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
               HOLD, REPEAT: begin
                  if (!lvl_s[g]) begin
                     state_nxt_s = IDLE;
                     tmr_nxt_s   = '0;
                  end else if (tmr_r == '0) begin
                     pulse_k_s   = 1'b1;
                     state_nxt_s = REPEAT;
                     tmr_nxt_s   = PERIOD_LOAD;
                  end else begin
                     tmr_nxt_s   = tmr_r - TW'(1);
                  end
               end
`endif
               PRESSED: begin
                  if (!lvl_s[g]) begin
                     state_nxt_s = IDLE;
                  end else begin
                     state_nxt_s = PRESSED;
                  end
               end
               default: begin
                  state_nxt_s = IDLE;
               end
            endcase
         end
      end

      // key state and repeat timer registers
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_r <= IDLE;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
            tmr_r   <= '0;
`endif
         end else begin
            state_r <= state_nxt_s;
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
            tmr_r   <= tmr_nxt_s;
`endif
         end
      end

      assign pulse_s[g] = pulse_k_s;
   end

   // registered outputs; pulses are masked while both keys are down
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         up_r   <= 1'b0;
         down_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         up_r   <= pulse_s[0] & ~both_s;
         down_r <= pulse_s[1] & ~both_s;
         busy_r <= lvl_s[0] | lvl_s[1];
      end
   end

   assign up   = up_r;
   assign down = down_r;
   assign busy = busy_r;

endmodule

// File: tb/tb_updown_key_ctrl.sv
// Self-checking bench for updown_key_ctrl: directed scenarios plus random button
// activity, compared every cycle against a behavioural pulse-schedule model.
module tb_updown_key_ctrl;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic btn_up   = 1'b0;
   logic btn_down = 1'b0;
   logic up;
   logic down;
   logic busy;

   int n_vec = 0;
   int n_err = 0;
   int n_up  = 0;
   int n_down = 0;

   // model state: raw history, debounce run lengths, debounced levels, press start edge
   int m_edge = 0;
   bit m_s1 [2];
   bit m_s2 [2];
   bit m_lvl [2];
   int m_run [2];
   bit m_act [2];
   int m_p0 [2];
   bit e_up, e_down, e_busy;

   always #5 clk = ~clk;

   updown_key_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .up       (up),
      .down     (down),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One clock edge of the reference model: outputs after this edge, then state update.
   task automatic model_step(input bit rst, input bit raw_u, input bit raw_d);
      bit pl [2];
      bit raw [2];
      bit both;
      int age;
      raw[0] = raw_u;
      raw[1] = raw_d;
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_act[b] = 0; m_p0[b] = 0;
         end
         e_up = 0; e_down = 0; e_busy = 0;
      end else begin
         both = m_lvl[0] & m_lvl[1];
         for (int b = 0; b < 2; b++) begin
            pl[b] = 0;
            if (!m_lvl[b] || both) begin
               m_act[b] = 0;
            end else if (!m_act[b]) begin
               m_act[b] = 1;
               m_p0[b]  = m_edge;
               pl[b]    = 1;
            end else begin
               age = m_edge - m_p0[b];
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
               pl[b] = (age == RD) || (age > RD && ((age - RD) % RP) == 0);
`else
               pl[b] = (age < 0);
`endif
            end
         end
         e_up   = pl[0];
         e_down = pl[1];
         e_busy = m_lvl[0] | m_lvl[1];
         for (int b = 0; b < 2; b++) begin
            if (m_s2[b] != m_lvl[b]) begin
               m_run[b]++;
               if (m_run[b] == DB) begin
                  m_lvl[b] = m_s2[b];
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
         end
      end
      m_edge++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(rst_n, btn_up, btn_down);
      #1;
      check("up", up, e_up);
      check("down", down, e_down);
      check("busy", busy, e_busy);
      check("exclusive", up & down, 0);
      if (up === 1'b1) n_up++;
      if (down === 1'b1) n_down++;
   endtask

   task automatic wait_up(input int limit, output int at);
      at = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (up === 1'b1) begin
            at = i;
            break;
         end
      end
   endtask

   initial begin
      int at;
      int c0;
      int hold_exp;

      // reset held with the button already pressed
      btn_up = 1'b1;
      repeat (3) tick();
      check("rst_up", up, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_up(20, at);
      check("rst_first_up", at, 7);
      btn_up = 1'b0;
      repeat (15) tick();

      // glitch shorter than the debounce window
      c0 = n_up;
      btn_up = 1'b1;
      repeat (3) tick();
      btn_up = 1'b0;
      repeat (15) tick();
      check("glitch_pulses", n_up - c0, 0);

      // single short press
      c0 = n_down;
      btn_up = 1'b1;
      wait_up(20, at);
      check("press_latency", at, 7);
      tick();
      btn_up = 1'b0;
      repeat (15) tick();
      check("press_no_down", n_down - c0, 0);

      // held decrement key
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
      hold_exp = 8;
`else
      hold_exp = 1;
`endif
      c0 = n_down;
      btn_down = 1'b1;
      repeat (30) tick();
      btn_down = 1'b0;
      repeat (15) tick();
      check("hold_pulses", n_down - c0, hold_exp);

      // both keys together, then release decrement
      c0 = n_up + n_down;
      btn_up = 1'b1;
      btn_down = 1'b1;
      repeat (20) tick();
      check("both_suppressed", n_up + n_down - c0, 0);
      btn_down = 1'b0;
      wait_up(20, at);
      check("both_release_up", at, 7);
`ifdef UPDOWN_KEY_AUTO_REPEAT_EN
      wait_up(15, at);
      check("both_rep1", at, 10);
      wait_up(6, at);
      check("both_rep2", at, 3);
`else
      c0 = n_up;
      repeat (20) tick();
      check("both_no_repeat", n_up - c0, 0);
`endif
      btn_up = 1'b0;
      repeat (15) tick();

      // reset in the middle of a long hold
      btn_up = 1'b1;
      repeat (25) tick();
      rst_n = 1'b0;
      tick();
      check("midrst_up", up, 0);
      check("midrst_busy", busy, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      wait_up(20, at);
      check("midrst_fresh", at, 7);
      btn_up = 1'b0;
      repeat (15) tick();

      // random button activity with occasional resets
      for (int s = 0; s < 250; s++) begin
         btn_up   = ($urandom_range(0, 2) == 0);
         btn_down = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 24) == 0) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            rst_n = 1'b1;
         end
         repeat ($urandom_range(1, 40)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
